pll_lock_supervisor: RTL

- Closes the control loop around the project's PLL wrappers (e.g. the FFT PLL).
- Samples the PLL LOCK output and drives the PLL RST input.
- Holds downstream logic in reset until lock has been stable for a programmed time.
- On lost or never-achieved lock: re-resets the PLL with bounded retries, then latches a failure flag. Runs on the free-running board reference clock (50 MHz), never on a PLL output.

---
 rtl/pll_sup_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 29 ++
 rtl/pll_lock_supervisor.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
// State encoding, synchroniser depth and parameter range checks.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_e;

    localparam int SYNC_STAGES = 2;

    // True when a non-negative value is representable in width bits.
    function automatic bit fits(input int value, input int width);
        return (value >= 0) && ((longint'(value) >> width) == 64'd0);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit multi-flop synchroniser, async active-low reset to 0.
// Reusable for any PLL LOCK or similar asynchronous level.
module sync_2ff
    import pll_sup_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives PLL reset from synchronised LOCK, releases downstream reset
// after stable lock, retries on timeout and latches a terminal failure.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 5000,
    parameter int LOSS_FILT     = 8,
    parameter int MAX_RETRY     = 4,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       pll_ready,
    output logic       fail,
    output logic [2:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    if (MAX_RETRY < 1 || MAX_RETRY > 7) begin : g_bad_retry
        $error("MAX_RETRY must be within 1..7");
    end
    if (RST_CYCLES < 1 || LOCK_TIMEOUT < 2 ||
        STABLE_CYCLES < 1 || LOSS_FILT < 1) begin : g_bad_range
        $error("cycle parameters below minimum");
    end
    if (!fits(RST_CYCLES, CNT_W) || !fits(LOCK_TIMEOUT, CNT_W) ||
        !fits(STABLE_CYCLES, CNT_W) ||
        !fits(LOSS_FILT, CNT_W)) begin : g_bad_width
        $error("CNT_W too narrow for cycle parameters");
    end

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LF_LAST  = CNT_W'(LOSS_FILT - 1);
    localparam logic [2:0]       RETRY_MX = 3'(MAX_RETRY);

    logic lock_s;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [2:0]       retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic             pll_rst_q, pll_rst_d;
    logic             run_q, run_d;
    logic             fail_q, fail_d;
    logic [2:0]       retry_inc;

    assign retry_inc = retry_q + 3'd1;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        retry_d = retry_q;
        loss_d  = loss_q;
        unique case (state_q)
            RESET_PLL: begin
                if (timer_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    timer_d = '0;
                end
            end
            WAIT_LOCK: begin
                // Lock seen on the timeout cycle wins over the retry.
                if (lock_s) begin
                    state_d = STABLE;
                    timer_d = '0;
                end else if (timer_q == TO_LAST) begin
                    retry_d = retry_inc;
                    timer_d = '0;
                    state_d = (retry_inc == RETRY_MX) ? FAIL : RESET_PLL;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    timer_d = '0;
                end else if (timer_q == ST_LAST) begin
                    state_d = RUN;
                    timer_d = '0;
                    retry_d = '0;
                end
            end
            RUN: begin
                if (lock_s) begin
                    timer_d = '0;
                end else if (timer_q == LF_LAST) begin
                    state_d = RESET_PLL;
                    timer_d = '0;
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 8'd1;
                    end
                end
            end
            FAIL: begin
                timer_d = timer_q;
            end
            default: begin
                state_d = RESET_PLL;
                timer_d = '0;
            end
        endcase
        pll_rst_d = (state_d == RESET_PLL) || (state_d == FAIL);
        run_d     = (state_d == RUN);
        fail_d    = (state_d == FAIL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RESET_PLL;
            timer_q   <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            pll_rst_q <= 1'b1;
            run_q     <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            pll_rst_q <= pll_rst_d;
            run_q     <= run_d;
            fail_q    <= fail_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = run_q;
    assign pll_ready = run_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;

endmodule
